// File: rtl/nv_ram_pkg.sv
// Shared types and helpers for the nv_ram_* family of FPGA RAM models.
package nv_ram_pkg;

   localparam int RD_LAT_MIN = 1;
   localparam int RD_LAT_MAX = 2;

   typedef enum logic {
      ST_INIT = 1'b0,
      ST_RUN  = 1'b1
   } ram_state_e;

   // Address width needed to index n words; returns at least 1.
   function automatic int clog2(input int n);
      int r;
      int v;
      r = 0;
      v = n - 1;
      while (v > 0) begin
         r++;
         v = v >> 1;
      end
      if (r == 0) r = 1;
      return r;
   endfunction

endpackage

// File: rtl/nv_ram_pe_outpipe.sv
// Read output pipeline: STAGES valid-gated data/valid register stages, one cycle each.
// No backpressure; each data register loads only when its incoming valid is set.
module nv_ram_pe_outpipe #(
   parameter int DW     = 256,
   parameter int STAGES = 1
) (
   input  logic          clk,
   input  logic          rstn,
   input  logic          in_vld,
   input  logic [DW-1:0] in_dat,
   output logic          out_vld,
   output logic [DW-1:0] out_dat
);

   logic [STAGES-1:0] vld_q;
   logic [DW-1:0]     dat_q   [STAGES];
   logic [STAGES:0]   v_chain;
   logic [DW-1:0]     d_chain [STAGES+1];

   assign v_chain = {vld_q, in_vld};

   always_comb begin
      d_chain[0] = in_dat;
      for (int s = 0; s < STAGES; s++) begin
         d_chain[s+1] = dat_q[s];
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         vld_q <= '0;
         for (int s = 0; s < STAGES; s++) begin
            dat_q[s] <= '0;
         end
      end else begin
         for (int s = 0; s < STAGES; s++) begin
            vld_q[s] <= v_chain[s];
            // Hold the last result when no read advances through this stage.
            if (v_chain[s]) dat_q[s] <= d_chain[s];
         end
      end
   end

   assign out_vld = vld_q[STAGES-1];
   assign out_dat = dat_q[STAGES-1];

endmodule

// File: rtl/nv_ram_rwsp_pe.sv
// Two-port RAM (1R/1W) with byte-masked writes, post-reset zero fill and RD_LAT-cycle reads.
// No backpressure: a read accepted at edge N returns after RD_LAT cycles; traffic ignored until init_done.
module nv_ram_rwsp_pe
   import nv_ram_pkg::*;
#(
   parameter  int DEPTH         = 512,
   parameter  int DW            = 256,
   parameter  int RD_LAT        = 1,
   parameter  int WR_FIRST      = 1,
   parameter  int INIT_ON_RESET = 1,
   localparam int AW            = clog2(DEPTH),
   localparam int MW            = DW / 8
) (
   input  logic          clk,
   input  logic          rstn,
   input  logic [AW-1:0] ra,
   input  logic          re,
   output logic [DW-1:0] dout,
   output logic          dout_vld,
   input  logic [AW-1:0] wa,
   input  logic          we,
   input  logic [MW-1:0] wmask,
   input  logic [DW-1:0] di,
   output logic          init_done,
   input  logic [31:0]   pwrbus_ram_pd
);

   localparam ram_state_e ST_RST = (INIT_ON_RESET != 0) ? ST_INIT : ST_RUN;

   if (DEPTH < 2) begin : g_chk_depth
      $error("nv_ram_rwsp_pe: DEPTH must be >= 2");
   end
   if ((DW < 8) || ((DW % 8) != 0)) begin : g_chk_dw
      $error("nv_ram_rwsp_pe: DW must be a non-zero multiple of 8");
   end
   if ((RD_LAT < RD_LAT_MIN) || (RD_LAT > RD_LAT_MAX)) begin : g_chk_lat
      $error("nv_ram_rwsp_pe: RD_LAT must be 1 or 2");
   end
   if ((WR_FIRST != 0) && (WR_FIRST != 1)) begin : g_chk_wrf
      $error("nv_ram_rwsp_pe: WR_FIRST must be 0 or 1");
   end
   if ((INIT_ON_RESET != 0) && (INIT_ON_RESET != 1)) begin : g_chk_init
      $error("nv_ram_rwsp_pe: INIT_ON_RESET must be 0 or 1");
   end

   ram_state_e    state_q;
   ram_state_e    state_d;
   logic [AW-1:0] cnt_q;
   logic          init_done_q;
   logic          fill_we;
   logic          wr_go;
   logic          rd_go;
   logic [DW-1:0] mem [DEPTH];
   logic [DW-1:0] rd_old;
   logic [DW-1:0] rd_merge;
   logic [DW-1:0] rd_dat;
   logic          unused_pwr;

   assign unused_pwr = ^pwrbus_ram_pd;

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) state_q <= ST_RST;
      else       state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_INIT: if (cnt_q == AW'(DEPTH - 1)) state_d = ST_RUN;
         ST_RUN:  state_d = ST_RUN;
         default: state_d = ST_RST;
      endcase
   end

   always_comb begin
      fill_we = (state_q == ST_INIT);
   end

   // init_done tracks the edge that lands in RUN, and stays up until reset.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         cnt_q       <= '0;
         init_done_q <= 1'b0;
      end else begin
         if (fill_we) cnt_q <= cnt_q + AW'(1);
         init_done_q <= init_done_q | (state_d == ST_RUN);
      end
   end

   assign init_done = init_done_q;
   assign wr_go     = init_done_q & we;
   assign rd_go     = init_done_q & re;

   always_ff @(posedge clk) begin
      if (fill_we) begin
         mem[cnt_q] <= '0;
      end else if (wr_go) begin
         for (int i = 0; i < MW; i++) begin
            if (wmask[i]) mem[wa][8*i +: 8] <= di[8*i +: 8];
         end
      end
   end

   assign rd_old = mem[ra];

   always_comb begin
      rd_merge = rd_old;
      for (int i = 0; i < MW; i++) begin
         if (wmask[i]) rd_merge[8*i +: 8] = di[8*i +: 8];
      end
   end

   // Same-address collision: write-first forwards the merged word, read-first sees the old one.
   assign rd_dat = ((WR_FIRST != 0) && wr_go && (ra == wa)) ? rd_merge : rd_old;

   nv_ram_pe_outpipe #(
      .DW     (DW),
      .STAGES (RD_LAT)
   ) u_outpipe (
      .clk     (clk),
      .rstn    (rstn),
      .in_vld  (rd_go),
      .in_dat  (rd_dat),
      .out_vld (dout_vld),
      .out_dat (dout)
   );

   a_ra_range: assert property (@(posedge clk) disable iff (!rstn)
      rd_go |-> ({1'b0, ra} < (AW+1)'(DEPTH)));
   a_wa_range: assert property (@(posedge clk) disable iff (!rstn)
      wr_go |-> ({1'b0, wa} < (AW+1)'(DEPTH)));

endmodule
